// File: rtl/muldiv_issue.sv
// muldiv_issue: issue/writeback sequencer for RV32M multiply and divide operations.
// It accepts one instruction at a time from decode and classifies it. A multiply is
// handed to a fixed-latency multiplier. A divide is handed to a variable-latency
// divider that has a timeout. The result is then presented to the register file.
//
// Ports:
//   clk_i, rst_i                     clock, asynchronous active-high reset
//   in_valid_i / in_ready_o          decode handshake
//   in_opcode_i, in_pc_i,            instruction fields, latched on acceptance
//   in_rd_idx_i, in_ra_operand_i,
//   in_rb_operand_i
//   flush_i                          cancel the in-flight operation
//   mul_valid_o, mul_opcode_o,       multiplier issue (the valid is a one-cycle pulse)
//   mul_ra_operand_o,
//   mul_rb_operand_o
//   mul_result_i                     multiplier result
//   div_valid_o, div_opcode_o,       divider issue (the valid is a one-cycle pulse)
//   div_ra_operand_o,
//   div_rb_operand_o
//   div_result_valid_i,              divider completion
//   div_result_i
//   wb_valid_o / wb_ready_i,         register-file writeback
//   wb_rd_idx_o, wb_value_o,
//   wb_pc_o
//   busy_o                           high whenever the sequencer is not idle
//   error_o                          one-cycle pulse on an illegal opcode or a divider timeout
module muldiv_issue #(
   parameter int unsigned MUL_LATENCY = 2,
   parameter int unsigned DIV_TIMEOUT = 40
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        in_valid_i,
   output logic        in_ready_o,
   input  logic [31:0] in_opcode_i,
   input  logic [31:0] in_pc_i,
   input  logic [4:0]  in_rd_idx_i,
   input  logic [31:0] in_ra_operand_i,
   input  logic [31:0] in_rb_operand_i,
   input  logic        flush_i,
   output logic        mul_valid_o,
   output logic [31:0] mul_opcode_o,
   output logic [31:0] mul_ra_operand_o,
   output logic [31:0] mul_rb_operand_o,
   input  logic [31:0] mul_result_i,
   output logic        div_valid_o,
   output logic [31:0] div_opcode_o,
   output logic [31:0] div_ra_operand_o,
   output logic [31:0] div_rb_operand_o,
   input  logic        div_result_valid_i,
   input  logic [31:0] div_result_i,
   output logic        wb_valid_o,
   input  logic        wb_ready_i,
   output logic [4:0]  wb_rd_idx_o,
   output logic [31:0] wb_value_o,
   output logic [31:0] wb_pc_o,
   output logic        busy_o,
   output logic        error_o
);

   localparam int unsigned CNT_MAX  = (MUL_LATENCY > DIV_TIMEOUT) ? MUL_LATENCY : DIV_TIMEOUT;
   localparam int unsigned CNT_W    = $clog2(CNT_MAX + 2);
   localparam int unsigned DIV_LAST = (DIV_TIMEOUT > 0) ? DIV_TIMEOUT - 1 : 0;

   typedef enum logic [2:0] {IDLE, MUL_WAIT, DIV_WAIT, DIV_DRAIN, WB} state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               mul_valid_q, mul_valid_d;
   logic               div_valid_q, div_valid_d;
   logic               error_q, error_d;
   logic [31:0]        result_q, result_d;
   logic [31:0]        opcode_q, pc_q, ra_q, rb_q;
   logic [4:0]         rd_q;
   logic               accept;
   logic               is_mop;
   logic               div_done;

   assign in_ready_o = (state_q == IDLE) && !flush_i && !rst_i;
   assign accept     = in_valid_i && in_ready_o;
   assign is_mop     = (in_opcode_i[6:0] == 7'b0110011) && (in_opcode_i[31:25] == 7'b0000001);
   assign div_done   = (cnt_q >= CNT_W'(DIV_LAST));

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      mul_valid_d = 1'b0;
      div_valid_d = 1'b0;
      error_d     = 1'b0;
      result_d    = result_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (!is_mop) begin
                  error_d = 1'b1;
               end else if (in_opcode_i[14]) begin
                  div_valid_d = 1'b1;
                  cnt_d       = '0;
                  state_d     = DIV_WAIT;
               end else begin
                  mul_valid_d = 1'b1;
                  cnt_d       = CNT_W'(MUL_LATENCY);
                  state_d     = MUL_WAIT;
               end
            end
         end
         MUL_WAIT: begin
            if (flush_i) begin
               cnt_d   = '0;
               state_d = IDLE;
            end else if (!mul_valid_q) begin
               // The issue cycle itself does not count down, which places the first
               // wb_valid_o cycle MUL_LATENCY+2 edges after acceptance.
               if (cnt_q == '0) begin
                  result_d = mul_result_i;
                  state_d  = (rd_q == 5'd0) ? IDLE : WB;
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
         end
         DIV_WAIT: begin
            if (div_result_valid_i) begin
               cnt_d = '0;
               if (flush_i || rd_q == 5'd0) begin
                  state_d = IDLE;
               end else begin
                  result_d = div_result_i;
                  state_d  = WB;
               end
            end else if (flush_i) begin
               cnt_d   = cnt_q + 1'b1;
               state_d = DIV_DRAIN;
            end else if (div_done) begin
               cnt_d   = '0;
               error_d = 1'b1;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DIV_DRAIN: begin
            // The divider is still busy with the cancelled op; wait it out silently.
            if (div_result_valid_i || div_done) begin
               cnt_d   = '0;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         WB: begin
            if (wb_ready_i || flush_i) begin
               state_d = IDLE;
            end
         end
         default: begin
            cnt_d   = '0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         mul_valid_q <= 1'b0;
         div_valid_q <= 1'b0;
         error_q     <= 1'b0;
         result_q    <= '0;
         opcode_q    <= '0;
         pc_q        <= '0;
         ra_q        <= '0;
         rb_q        <= '0;
         rd_q        <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         mul_valid_q <= mul_valid_d;
         div_valid_q <= div_valid_d;
         error_q     <= error_d;
         result_q    <= result_d;
         if (accept) begin
            opcode_q <= in_opcode_i;
            pc_q     <= in_pc_i;
            ra_q     <= in_ra_operand_i;
            rb_q     <= in_rb_operand_i;
            rd_q     <= in_rd_idx_i;
         end
      end
   end

   assign mul_valid_o      = mul_valid_q;
   assign mul_opcode_o     = opcode_q;
   assign mul_ra_operand_o = ra_q;
   assign mul_rb_operand_o = rb_q;
   assign div_valid_o      = div_valid_q;
   assign div_opcode_o     = opcode_q;
   assign div_ra_operand_o = ra_q;
   assign div_rb_operand_o = rb_q;
   assign wb_valid_o       = (state_q == WB);
   assign wb_rd_idx_o      = rd_q;
   assign wb_value_o       = result_q;
   assign wb_pc_o          = pc_q;
   assign busy_o           = (state_q != IDLE);
   assign error_o          = error_q;

endmodule

// File: tb/tb_muldiv_issue.sv
// Directed testbench for muldiv_issue. It contains a 2-cycle multiplier model and a
// divider model that completes 33 cycles after issue (the divider model can be disabled).
module tb_muldiv_issue;

   localparam int unsigned DIV_DELAY = 33;
   localparam logic [31:0] OP_MUL = 32'h0200_0033;
   localparam logic [31:0] OP_DIV = 32'h0200_4033;
   localparam logic [31:0] OP_REM = 32'h0200_6033;
   localparam logic [31:0] OP_ADDI = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready, flush;
   logic [31:0] in_opcode, in_pc, in_ra, in_rb;
   logic [4:0]  in_rd;
   logic        mul_valid, div_valid, wb_valid, wb_ready, busy, error;
   logic [31:0] mul_opcode, mul_ra, mul_rb, mul_result;
   logic [31:0] div_opcode, div_ra, div_rb, div_result;
   logic        div_result_valid;
   logic [4:0]  wb_rd_idx;
   logic [31:0] wb_value, wb_pc;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   muldiv_issue #(.MUL_LATENCY(2), .DIV_TIMEOUT(40)) dut (
      .clk_i(clk), .rst_i(rst),
      .in_valid_i(in_valid), .in_ready_o(in_ready),
      .in_opcode_i(in_opcode), .in_pc_i(in_pc), .in_rd_idx_i(in_rd),
      .in_ra_operand_i(in_ra), .in_rb_operand_i(in_rb),
      .flush_i(flush),
      .mul_valid_o(mul_valid), .mul_opcode_o(mul_opcode),
      .mul_ra_operand_o(mul_ra), .mul_rb_operand_o(mul_rb), .mul_result_i(mul_result),
      .div_valid_o(div_valid), .div_opcode_o(div_opcode),
      .div_ra_operand_o(div_ra), .div_rb_operand_o(div_rb),
      .div_result_valid_i(div_result_valid), .div_result_i(div_result),
      .wb_valid_o(wb_valid), .wb_ready_i(wb_ready), .wb_rd_idx_o(wb_rd_idx),
      .wb_value_o(wb_value), .wb_pc_o(wb_pc),
      .busy_o(busy), .error_o(error)
   );

   // Multiplier model: the product is valid two cycles after the issue pulse and held.
   logic [31:0] mpipe0 = '0, mpipe1 = '0;
   always @(posedge clk) begin
      if (mul_valid) mpipe0 <= mul_ra * mul_rb;
      mpipe1 <= mpipe0;
   end
   assign mul_result = mpipe1;

   // Divider model: the completion pulse arrives DIV_DELAY cycles after the issue cycle.
   logic div_model_on = 1'b1;
   logic dpend = 1'b0;
   int   dcnt  = 0;
   initial begin
      div_result_valid = 1'b0;
      div_result       = '0;
   end
   always @(posedge clk) begin
      div_result_valid <= 1'b0;
      if (rst) begin
         dpend <= 1'b0;
      end else if (div_valid && div_model_on) begin
         dpend      <= 1'b1;
         dcnt       <= 1;
         div_result <= (div_rb == 0) ? 32'hFFFF_FFFF :
                       (div_opcode[13] ? div_ra % div_rb : div_ra / div_rb);
      end else if (dpend) begin
         if (dcnt == DIV_DELAY - 1) begin
            div_result_valid <= 1'b1;
            dpend            <= 1'b0;
         end
         dcnt <= dcnt + 1;
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   // Presents one instruction for one cycle. On return the bench is in the cycle
   // right after the acceptance edge (cycle 0).
   task automatic accept(input logic [31:0] op, input logic [31:0] pc, input logic [4:0] rd,
                         input logic [31:0] a, input logic [31:0] b);
      in_opcode = op; in_pc = pc; in_rd = rd; in_ra = a; in_rb = b;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      tick();
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_checks++; if ({mul_valid, div_valid, wb_valid, error} !== 4'b0) begin n_fail++; $display("FAIL reset_valids: got %b want 0000", {mul_valid, div_valid, wb_valid, error}); end
      n_checks++; if ({wb_value, wb_pc, mul_opcode} !== 96'b0) begin n_fail++; $display("FAIL reset_data: got %h want 0", {wb_value, wb_pc, mul_opcode}); end
      rst = 1'b0;
      #1;
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b want 1", in_ready); end
      tick();
   endtask

   task automatic test_mul();
      int pulses = 0;
      accept(OP_MUL, 32'h100, 5'd5, 32'hA, 32'h3);
      n_checks++; if (mul_valid !== 1'b1) begin n_fail++; $display("FAIL mul_issue_valid: got %b want 1", mul_valid); end
      n_checks++; if ({mul_opcode, mul_ra, mul_rb} !== {OP_MUL, 32'hA, 32'h3}) begin n_fail++; $display("FAIL mul_issue_fields: got %h want %h", {mul_opcode, mul_ra, mul_rb}, {OP_MUL, 32'hA, 32'h3}); end
      for (int c = 1; c <= 3; c++) begin
         tick();
         if (mul_valid) pulses++;
         n_checks++; if ({wb_valid, busy, div_valid} !== 3'b010) begin n_fail++; $display("FAIL mul_wait_c%0d: wb/busy/div got %b want 010", c, {wb_valid, busy, div_valid}); end
      end
      n_checks++; if (pulses !== 0) begin n_fail++; $display("FAIL mul_single_pulse: extra pulses %0d want 0", pulses); end
      tick();
      n_checks++; if (wb_valid !== 1'b1) begin n_fail++; $display("FAIL mul_wb_timing: got %b want 1 at acceptance+4", wb_valid); end
      n_checks++; if ({wb_value, wb_rd_idx, wb_pc} !== {32'h1E, 5'd5, 32'h100}) begin n_fail++; $display("FAIL mul_wb_fields: got %h/%0d/%h want 1e/5/100", wb_value, wb_rd_idx, wb_pc); end
      tick();
      n_checks++; if ({wb_valid, busy, in_ready} !== 3'b001) begin n_fail++; $display("FAIL mul_after_wb: wb/busy/ready got %b want 001", {wb_valid, busy, in_ready}); end
   endtask

   task automatic run_div(input logic [31:0] op, input logic [31:0] want, input string name);
      int wb_cyc = -1;
      accept(op, 32'h300, 5'd7, 32'h14, 32'h5);
      n_checks++; if (div_valid !== 1'b1 || mul_valid !== 1'b0) begin n_fail++; $display("FAIL %s_issue: div/mul got %b%b want 10", name, div_valid, mul_valid); end
      for (int c = 1; c <= 60 && wb_cyc < 0; c++) begin
         tick();
         if (busy !== 1'b1) begin n_fail++; $display("FAIL %s_busy_c%0d: got %b want 1", name, c, busy); end
         if (div_valid !== 1'b0) begin n_fail++; $display("FAIL %s_div_pulse_c%0d: got %b want 0", name, c, div_valid); end
         if (wb_valid) wb_cyc = c;
      end
      n_checks += 2;
      n_checks++; if (wb_cyc !== 34) begin n_fail++; $display("FAIL %s_wb_cycle: got %0d want 34", name, wb_cyc); end
      n_checks++; if (wb_value !== want || wb_rd_idx !== 5'd7) begin n_fail++; $display("FAIL %s_value: got %h rd %0d want %h rd 7", name, wb_value, wb_rd_idx, want); end
      tick();
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL %s_idle: in_ready got %b want 1", name, in_ready); end
   endtask

   task automatic test_div();
      run_div(OP_DIV, 32'h4, "div");
      run_div(OP_REM, 32'h0, "rem");
   endtask

   task automatic test_wb_stall();
      int waited = 0;
      wb_ready = 1'b0;
      accept(OP_MUL, 32'h200, 5'd3, 32'd7, 32'd6);
      while (!wb_valid && waited < 10) begin tick(); waited++; end
      n_checks++; if (waited !== 4) begin n_fail++; $display("FAIL stall_wb_arrival: got %0d want 4", waited); end
      for (int c = 0; c < 5; c++) begin
         n_checks++;
         if ({wb_valid, in_ready, wb_value, wb_rd_idx, wb_pc} !== {2'b10, 32'd42, 5'd3, 32'h200}) begin
            n_fail++;
            $display("FAIL stall_hold_c%0d: valid/ready %b%b value %h rd %0d pc %h want 10/2a/3/200", c, wb_valid, in_ready, wb_value, wb_rd_idx, wb_pc);
         end
         tick();
      end
      wb_ready = 1'b1;
      n_checks++; if ({wb_valid, in_ready} !== 2'b10) begin n_fail++; $display("FAIL stall_pre_handshake: got %b want 10", {wb_valid, in_ready}); end
      tick();
      n_checks++; if ({wb_valid, in_ready} !== 2'b01) begin n_fail++; $display("FAIL stall_post_handshake: got %b want 01", {wb_valid, in_ready}); end
   endtask

   task automatic test_rd0_illegal();
      int wbs = 0, errs = 0;
      accept(OP_MUL, 32'h400, 5'd0, 32'd9, 32'd9);
      for (int c = 0; c < 8; c++) begin
         if (wb_valid) wbs++;
         if (error) errs++;
         tick();
      end
      n_checks++; if (wbs !== 0 || errs !== 0) begin n_fail++; $display("FAIL rd0_discard: wb %0d err %0d want 0/0", wbs, errs); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rd0_idle: busy got %b want 0", busy); end
      accept(OP_ADDI, 32'h404, 5'd2, 32'd1, 32'd1);
      n_checks++; if ({error, mul_valid, div_valid, busy} !== 4'b1000) begin n_fail++; $display("FAIL illegal_pulse: err/mul/div/busy got %b want 1000", {error, mul_valid, div_valid, busy}); end
      tick();
      n_checks++; if ({error, wb_valid, in_ready} !== 3'b001) begin n_fail++; $display("FAIL illegal_after: err/wb/ready got %b want 001", {error, wb_valid, in_ready}); end
   endtask

   task automatic test_flush_div();
      int bad = 0;
      accept(OP_DIV, 32'h500, 5'd8, 32'd100, 32'd10);
      tick(); tick(); tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      for (int c = 4; c <= 33; c++) begin
         if (in_ready !== 1'b0 || wb_valid !== 1'b0 || error !== 1'b0) begin
            bad++;
            $display("FAIL flush_div_drain_c%0d: ready/wb/err got %b%b%b want 000", c, in_ready, wb_valid, error);
         end
         tick();
      end
      n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL flush_div_drain: %0d bad cycles want 0", bad); end
      n_checks++; if ({in_ready, busy, wb_valid, error} !== 4'b1000) begin n_fail++; $display("FAIL flush_div_release: ready/busy/wb/err got %b want 1000", {in_ready, busy, wb_valid, error}); end
   endtask

   task automatic test_div_timeout();
      int err_cyc = -1, wbs = 0;
      div_model_on = 1'b0;
      accept(OP_DIV, 32'h600, 5'd9, 32'd50, 32'd5);
      for (int c = 0; c <= 45 && err_cyc < 0; c++) begin
         if (error) err_cyc = c;
         if (wb_valid) wbs++;
         if (err_cyc < 0) tick();
      end
      n_checks++; if (err_cyc !== 40) begin n_fail++; $display("FAIL timeout_cycle: got %0d want 40", err_cyc); end
      n_checks++; if (busy !== 1'b0 || wbs !== 0) begin n_fail++; $display("FAIL timeout_state: busy %b wb %0d want 0/0", busy, wbs); end
      tick();
      n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL timeout_pulse_width: got %b want 0", error); end
      div_model_on = 1'b1;
   endtask

   task automatic test_flush_mul();
      int wbs = 0;
      accept(OP_MUL, 32'h700, 5'd4, 32'd3, 32'd3);
      tick(); tick();
      flush = 1'b1;
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_mul_ready: got %b want 0", in_ready); end
      tick();
      flush = 1'b0;
      #1;
      n_checks++; if ({busy, in_ready} !== 2'b01) begin n_fail++; $display("FAIL flush_mul_idle: busy/ready got %b want 01", {busy, in_ready}); end
      for (int c = 0; c < 5; c++) begin if (wb_valid) wbs++; tick(); end
      n_checks++; if (wbs !== 0) begin n_fail++; $display("FAIL flush_mul_nowb: got %0d want 0", wbs); end
      // flush together with a presented instruction blocks acceptance
      flush = 1'b1;
      in_opcode = OP_MUL; in_rd = 5'd1; in_valid = 1'b1;
      #1;
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_idle_ready: got %b want 0", in_ready); end
      tick();
      in_valid = 1'b0; flush = 1'b0;
      n_checks++; if ({busy, mul_valid} !== 2'b00) begin n_fail++; $display("FAIL flush_idle_accept: busy/mul got %b want 00", {busy, mul_valid}); end
   endtask

   task automatic test_async_reset();
      int wbs = 0;
      accept(OP_MUL, 32'h800, 5'd6, 32'd5, 32'd5);
      tick(); tick();
      #2 rst = 1'b1;
      #1;
      n_checks++; if ({mul_valid, div_valid, wb_valid, busy, error, in_ready} !== 6'b0) begin n_fail++; $display("FAIL async_reset_ctl: got %b want 000000", {mul_valid, div_valid, wb_valid, busy, error, in_ready}); end
      n_checks++; if ({mul_opcode, mul_ra, wb_value, wb_pc, wb_rd_idx} !== 133'b0) begin n_fail++; $display("FAIL async_reset_data: got %h want 0", {mul_opcode, mul_ra, wb_value, wb_pc, wb_rd_idx}); end
      tick();
      rst = 1'b0;
      #1;
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL async_reset_ready: got %b want 1", in_ready); end
      for (int c = 0; c < 6; c++) begin tick(); if (wb_valid || busy) wbs++; end
      n_checks++; if (wbs !== 0) begin n_fail++; $display("FAIL async_reset_nowb: got %0d want 0", wbs); end
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; flush = 1'b0; wb_ready = 1'b1;
      in_opcode = '0; in_pc = '0; in_rd = '0; in_ra = '0; in_rb = '0;
      test_reset();
      test_mul();
      test_div();
      test_wb_stall();
      test_rd0_illegal();
      test_flush_div();
      test_div_timeout();
      test_flush_mul();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/muldiv_issue.md
MULDIV_ISSUE -- requirements
Module: muldiv_issue

Interface
REQ-001 Parameter MUL_LATENCY, default 2: cycles from mul_valid_o high to a valid mul_result_i.
REQ-002 Parameter DIV_TIMEOUT, default 40: max cycles waiting for div_result_valid_i before abort.
REQ-003 clk_i  in  1  single clock, all state on rising edge.
REQ-004 rst_i  in  1  asynchronous, active-high reset.
REQ-005 in_valid_i  in  1  decode presents instruction; in_ready_o  out  1  block can accept.
REQ-006 in_opcode_i  in  32 / in_pc_i  in  32 / in_rd_idx_i  in  5 / in_ra_operand_i  in  32 / in_rb_operand_i  in  32  instruction fields.
REQ-007 flush_i  in  1  cancel in-flight operation.
REQ-008 mul_valid_o  out  1 / mul_opcode_o  out  32 / mul_ra_operand_o  out  32 / mul_rb_operand_o  out  32  multiplier issue.
REQ-009 mul_result_i  in  32  multiplier writeback value.
REQ-010 div_valid_o  out  1 / div_opcode_o  out  32 / div_ra_operand_o  out  32 / div_rb_operand_o  out  32  divider issue.
REQ-011 div_result_valid_i  in  1 / div_result_i  in  32  divider completion.
REQ-012 wb_valid_o  out  1 / wb_ready_i  in  1 / wb_rd_idx_o  out  5 / wb_value_o  out  32 / wb_pc_o  out  32  register-file writeback.
REQ-013 busy_o  out  1  state is not IDLE; error_o  out  1  one-cycle pulse on illegal opcode or divider timeout.

Function
REQ-014 An M-op is opcode[6:0]=0110011 with opcode[31:25]=0000001; funct3[2]=0 means multiplier, funct3[2]=1 means divider.
REQ-015 States are IDLE, MUL_WAIT, DIV_WAIT, DIV_DRAIN and WB; in_ready_o=1 only in IDLE with flush_i=0.
REQ-016 Acceptance occurs on a rising edge with in_valid_i&in_ready_o; all in_* fields latch at that edge.
REQ-017 An accepted non-M opcode pulses error_o the next cycle, issues nothing, and stays in IDLE.
REQ-018 An accepted mul op drives mul_valid_o high for exactly one cycle (the cycle after acceptance), loads a counter with MUL_LATENCY and enters MUL_WAIT.
REQ-019 MUL_WAIT decrements the counter each cycle; at zero, mul_result_i is captured and the state moves to WB; wb_valid_o first rises MUL_LATENCY+2 cycles after the acceptance edge.
REQ-020 An accepted div op drives div_valid_o high for exactly one cycle and enters DIV_WAIT with the timeout counter cleared.
REQ-021 In DIV_WAIT, div_result_valid_i captures div_result_i and the state moves to WB.
REQ-022 In DIV_WAIT, reaching DIV_TIMEOUT cycles without completion pulses error_o and returns to IDLE with no writeback.
REQ-023 Issue outputs (opcode/operands) hold their latched values from issue until return to IDLE.
REQ-024 WB holds wb_valid_o and all wb_* fields stable until wb_valid_o&wb_ready_i, then returns to IDLE; next acceptance is possible the cycle after.
REQ-025 If the latched rd index is 0, the result is discarded, WB is skipped and the state returns to IDLE.
REQ-026 flush_i in MUL_WAIT or WB moves the state to IDLE with no wb_valid_o, except that a WB handshake completing in the same cycle stands.
REQ-027 flush_i in DIV_WAIT moves the state to DIV_DRAIN; DIV_DRAIN discards the result on div_result_valid_i or timeout (no error_o) and then returns to IDLE.
REQ-028 flush_i together with div_result_valid_i in DIV_WAIT moves the state directly to IDLE, result discarded.
REQ-029 flush_i with in_valid_i in IDLE means no acceptance.
REQ-030 div_result_valid_i outside DIV_WAIT/DIV_DRAIN is ignored.

Reset
REQ-031 While rst_i is high: state=IDLE, counters=0, and mul_valid_o, div_valid_o, wb_valid_o, busy_o and error_o are 0; all data outputs are 0; in_ready_o is 0.
REQ-032 Reset mid-operation abandons the operation with no writeback; in_ready_o=1 on the first cycle after rst_i falls.

Verification
REQ-033 MUL x1=0xA, x2=0x3, rd=5, 2-cycle multiplier model -> one mul_valid_o pulse; wb_valid_o at acceptance+4 cycles; wb_value_o=0x1E, wb_rd_idx_o=5.
REQ-034 DIV 0x14/0x5, rd=7, divider model completing after 33 cycles -> wb_value_o=0x4; busy_o high throughout; REM with the same operands -> 0x0.
REQ-035 wb_ready_i low for 5 cycles -> wb_* stable for 5 cycles; single handshake; in_ready_o stays 0 until after the handshake.
REQ-036 rd=0 MUL, then illegal opcode 0x00000013 -> no wb_valid_o; error_o pulses once for the illegal opcode only.
REQ-037 flush_i at DIV_WAIT+3, divider completing at +33 -> in_ready_o=0 until completion, no writeback; with the divider model never completing -> timeout at DIV_TIMEOUT with error_o.
REQ-038 rst_i asserted during MUL_WAIT -> all outputs 0 asynchronously; no writeback after release.
